// File: rtl/arb_resp_router.sv
// arb_resp_router
//   Return-path companion to a round-robin arbiter. Every request issued downstream has its
//   one-hot grant recorded in an in-order tag FIFO. Each downstream response is then routed
//   back to the requester port that issued it. When every tag slot is occupied, stall_o is
//   raised so the arbiter cannot issue more requests than the FIFO can track.
//
// Ports
//   clk_i, reset_i             clock (posedge); asynchronous active-high reset
//   grant_i, issue_valid_i     one-hot grant, qualified by issue_valid_i (push a tag)
//   stall_o                    tag FIFO full
//   resp_valid_i/data_i/ready_o  downstream response handshake
//   port_valid_o/data_o/ready_i  one-hot routed response towards the requester ports
//   outstanding_o              tags currently held
//   error_o                    sticky: [0] push while full, [1] multi-hot grant pushed
//
// Configuration
//   ARB_RESP_ROUTER_STATS_EN   adds resp_count_o, a wrapping count of delivered responses

module arb_resp_router #(
    parameter int unsigned VECTOR_IN  = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [VECTOR_IN-1:0]       grant_i,
    input  logic                       issue_valid_i,
    output logic                       stall_o,
    input  logic                       resp_valid_i,
    input  logic [DATA_WIDTH-1:0]      resp_data_i,
    output logic                       resp_ready_o,
    output logic [VECTOR_IN-1:0]       port_valid_o,
    output logic [DATA_WIDTH-1:0]      port_data_o,
    input  logic [VECTOR_IN-1:0]       port_ready_i,
    output logic [$clog2(DEPTH):0]     outstanding_o,
    output logic [1:0]                 error_o
`ifdef ARB_RESP_ROUTER_STATS_EN
    ,
    output logic [31:0]                resp_count_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [VECTOR_IN-1:0]  tags_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [VECTOR_IN-1:0]  pv_q, pv_d;
    logic [DATA_WIDTH-1:0] pd_q, pd_d;
    logic [1:0]            err_q, err_d;

    logic                  full;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  delivered;
    logic                  out_free;
    logic                  multi_hot;
    logic [VECTOR_IN-1:0]  grant_low;

    // Isolate the lowest set bit so a malformed grant still routes to exactly one port.
    assign grant_low = grant_i & (~grant_i + VECTOR_IN'(1));
    assign multi_hot = (grant_i & (grant_i - VECTOR_IN'(1))) != '0;

    assign full      = (count_q == CntW'(DEPTH));
    assign push_req  = issue_valid_i && (grant_i != '0);
    assign push      = push_req && !full;

    // Only the selected port's ready counts; ready on other ports is ignored.
    assign delivered = (pv_q & port_ready_i) != '0;
    assign out_free  = (pv_q == '0) || delivered;

    assign resp_ready_o = (count_q != '0) && out_free;
    assign pop          = resp_valid_i && resp_ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pv_d     = pv_q;
        pd_d     = pd_q;
        err_d    = err_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        // Full is judged on the registered count, so a same-cycle pop does not rescue the push.
        if (push_req && full) begin
            err_d[0] = 1'b1;
        end
        if (push && multi_hot) begin
            err_d[1] = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            pv_d     = tags_q[rd_ptr_q];
            pd_d     = resp_data_i;
        end else if (delivered) begin
            pv_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tags_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pv_q     <= '0;
            pd_q     <= '0;
            err_q    <= '0;
        end else begin
            if (push) begin
                tags_q[wr_ptr_q] <= grant_low;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pv_q     <= pv_d;
            pd_q     <= pd_d;
            err_q    <= err_d;
        end
    end

    assign stall_o       = full;
    assign port_valid_o  = pv_q;
    assign port_data_o   = pd_q;
    assign outstanding_o = count_q;
    assign error_o       = err_q;

`ifdef ARB_RESP_ROUTER_STATS_EN
    logic [31:0] resp_count_q, resp_count_d;

    always_comb begin
        resp_count_d = resp_count_q;
        if (delivered) begin
            resp_count_d = resp_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_count_q <= '0;
        end else begin
            resp_count_q <= resp_count_d;
        end
    end

    assign resp_count_o = resp_count_q;
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// tb_arb_resp_router
//   Directed scenarios followed by random traffic. A queue-based reference model predicts the
//   per-cycle handshake outputs; every accepted response pushes its expected {port, data} into
//   a scoreboard that an independent monitor drains on each observed delivery.

module tb_arb_resp_router;

    localparam int unsigned VI = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned D  = 8;

    typedef struct {
        logic [VI-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [VI-1:0] grant_i;
    logic          issue_valid_i;
    logic          stall_o;
    logic          resp_valid_i;
    logic [DW-1:0] resp_data_i;
    logic          resp_ready_o;
    logic [VI-1:0] port_valid_o;
    logic [DW-1:0] port_data_o;
    logic [VI-1:0] port_ready_i;
    logic [3:0]    outstanding_o;
    logic [1:0]    error_o;
`ifdef ARB_RESP_ROUTER_STATS_EN
    logic [31:0]   resp_count_o;
`endif

    arb_resp_router #(
        .VECTOR_IN  (VI),
        .DATA_WIDTH (DW),
        .DEPTH      (D)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .grant_i       (grant_i),
        .issue_valid_i (issue_valid_i),
        .stall_o       (stall_o),
        .resp_valid_i  (resp_valid_i),
        .resp_data_i   (resp_data_i),
        .resp_ready_o  (resp_ready_o),
        .port_valid_o  (port_valid_o),
        .port_data_o   (port_data_o),
        .port_ready_i  (port_ready_i),
        .outstanding_o (outstanding_o),
        .error_o       (error_o)
`ifdef ARB_RESP_ROUTER_STATS_EN
        ,
        .resp_count_o  (resp_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Reference model state: tags in issue order, the held output entry, sticky errors.
    logic [VI-1:0] m_tags [$];
    exp_t          exp_q [$];
    bit            m_held;
    logic [VI-1:0] m_held_tag;
    logic [DW-1:0] m_held_data;
    logic [1:0]    m_err;
    int unsigned   m_deliv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [VI-1:0] lowest_port(input logic [VI-1:0] g);
        logic [VI-1:0] r = '0;
        for (int i = 0; i < int'(VI); i++) begin
            if (g[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int ones(input logic [VI-1:0] g);
        int n = 0;
        for (int i = 0; i < int'(VI); i++) n += int'(g[i]);
        return n;
    endfunction

    // Monitor: every observed delivery must match the oldest accepted response.
    always @(negedge clk_i) begin
        if (!reset_i && ((port_valid_o & port_ready_i) != '0)) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL deliver_unexpected: got port %0h, expected no delivery", port_valid_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_port", 64'(port_valid_o), 64'(e.tag));
                chk("deliver_data", port_data_o, e.data);
            end
        end
    end

    // One cycle: entered at posedge+1, inputs applied, outputs checked at posedge+4,
    // model advanced as the next edge would, leaves at the following posedge+1.
    task automatic step(input bit iv, input logic [VI-1:0] g, input bit rv,
                        input logic [DW-1:0] rd, input logic [VI-1:0] pr);
        int  cnt;
        bit  free, rr, pop, deliv;
        issue_valid_i = iv;
        grant_i       = g;
        resp_valid_i  = rv;
        resp_data_i   = rd;
        port_ready_i  = pr;
        #3;
        cnt   = m_tags.size();
        deliv = m_held && ((m_held_tag & pr) != '0);
        free  = !m_held || deliv;
        rr    = (cnt != 0) && free;
        chk("resp_ready", 64'(resp_ready_o), 64'(rr));
        chk("stall", 64'(stall_o), 64'(cnt == int'(D)));
        chk("outstanding", 64'(outstanding_o), 64'(cnt));
        chk("error", 64'(error_o), 64'(m_err));
        chk("port_valid", 64'(port_valid_o), m_held ? 64'(m_held_tag) : 64'(0));
        if (m_held) chk("port_data", port_data_o, m_held_data);
`ifdef ARB_RESP_ROUTER_STATS_EN
        chk("resp_count", 64'(resp_count_o), 64'(m_deliv));
`endif
        pop = rv && rr;
        if (deliv) m_deliv++;
        if (pop) begin
            exp_t e;
            e.tag       = m_tags.pop_front();
            e.data      = rd;
            exp_q.push_back(e);
            m_held      = 1'b1;
            m_held_tag  = e.tag;
            m_held_data = rd;
        end else if (deliv) begin
            m_held = 1'b0;
        end
        if (iv && g != '0) begin
            if (cnt == int'(D)) begin
                m_err[0] = 1'b1;
            end else begin
                if (ones(g) > 1) m_err[1] = 1'b1;
                m_tags.push_back(lowest_port(g));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        issue_valid_i = 1'b0;
        grant_i       = '0;
        resp_valid_i  = 1'b0;
        resp_data_i   = '0;
        port_ready_i  = '0;
        reset_i       = 1'b1;
        #3;
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_resp_ready", 64'(resp_ready_o), 64'(0));
        chk("rst_port_valid", 64'(port_valid_o), 64'(0));
        chk("rst_port_data", port_data_o, 64'(0));
        chk("rst_outstanding", 64'(outstanding_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
`ifdef ARB_RESP_ROUTER_STATS_EN
        chk("rst_resp_count", 64'(resp_count_o), 64'(0));
`endif
        m_tags.delete();
        exp_q.delete();
        m_held      = 1'b0;
        m_held_tag  = '0;
        m_held_data = '0;
        m_err       = '0;
        m_deliv     = 0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        do_reset();

        // Single request/response.
        step(1, 8'h04, 0, '0, 8'h00);
        step(0, 8'h00, 0, '0, 8'h00);
        step(0, 8'h00, 1, 64'hA5, 8'h00);
        chk("t1_port_valid", 64'(port_valid_o), 64'h04);
        chk("t1_port_data", port_data_o, 64'hA5);
        step(0, 8'h00, 0, '0, 8'h04);
        chk("t1_cleared", 64'(port_valid_o), 64'h00);

        // In-order routing, back-to-back.
        step(1, 8'h01, 0, '0, 8'hFF);
        step(1, 8'h80, 0, '0, 8'hFF);
        step(1, 8'h10, 0, '0, 8'hFF);
        step(0, 8'h00, 1, 64'hD0, 8'hFF);
        step(0, 8'h00, 1, 64'hD1, 8'hFF);
        step(0, 8'h00, 1, 64'hD2, 8'hFF);
        step(0, 8'h00, 0, '0, 8'hFF);
`ifdef ARB_RESP_ROUTER_STATS_EN
        chk("t2_resp_count", 64'(resp_count_o), 64'd4);
`endif

        // Fill to capacity, then overflow.
        do_reset();
        for (int i = 0; i < int'(D); i++) step(1, 8'(1 << i), 0, '0, 8'h00);
        chk("t3_stall", 64'(stall_o), 64'(1));
        chk("t3_outstanding", 64'(outstanding_o), 64'(8));
        step(1, 8'h01, 0, '0, 8'h00);
        chk("t3_error", 64'(error_o), 64'h1);
        step(0, 8'h00, 1, 64'h33, 8'h00);
        chk("t3_unstall", 64'(stall_o), 64'(0));

        // Backpressure on a held response.
        do_reset();
        step(1, 8'h02, 0, '0, 8'h00);
        step(1, 8'h40, 0, '0, 8'h00);
        step(0, 8'h00, 1, 64'hBEEF, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 64'h1111, 8'hFD);
        chk("t4_hold_valid", 64'(port_valid_o), 64'h02);
        chk("t4_hold_data", port_data_o, 64'hBEEF);
        step(0, 8'h00, 1, 64'h2222, 8'h02);
        chk("t4_next_port", 64'(port_valid_o), 64'h40);
        step(0, 8'h00, 0, '0, 8'hFF);

        // Boundaries: empty response, multi-hot grant, pointer wrap.
        do_reset();
        step(0, 8'h00, 1, 64'h77, 8'hFF);
        step(0, 8'h00, 1, 64'h77, 8'hFF);
        step(1, 8'h06, 0, '0, 8'hFF);
        step(0, 8'h00, 1, 64'h66, 8'h00);
        chk("t5_multi_port", 64'(port_valid_o), 64'h02);
        chk("t5_multi_err", 64'(error_o), 64'h2);
        for (int i = 0; i < 20; i++) step(1, 8'(1 << (i % 8)), 1, 64'(100 + i), 8'hFF);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 64'(200 + i), 8'hFF);

        // Reset while busy.
        do_reset();
        step(1, 8'h08, 0, '0, 8'h00);
        step(1, 8'h20, 0, '0, 8'h00);
        step(1, 8'h01, 0, '0, 8'h00);
        step(0, 8'h00, 1, 64'h99, 8'h00);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bit            iv, rv;
            logic [VI-1:0] g, pr;
            int unsigned   r;
            iv = ($urandom % 3) != 0;
            r  = $urandom % 16;
            if (r == 0)      g = '0;
            else if (r == 1) g = 8'($urandom);
            else             g = 8'(1 << ($urandom % 8));
            rv = ($urandom % 10) < 7;
            pr = (($urandom % 2) == 0) ? 8'hFF : 8'($urandom);
            step(iv, g, rv, {$urandom, $urandom}, pr);
        end

        // Drain everything still in flight.
        for (int i = 0; i < int'(D) + 4; i++) step(0, 8'h00, 1, 64'(300 + i), 8'hFF);
        chk("drain_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
